// File: rtl/csa_resolve_accum_if.sv
// Beat-in / frame-result-out handshake bundle for csa_resolve_accum.
// slave is the resolver side, master the producer/consumer side.
interface csa_resolve_accum_if #(
  parameter int W     = 12,
  parameter int ACC_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     s_in;
  logic [W-1:0]     c_in;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_sat;

  modport slave (
    input  in_valid,
    input  s_in,
    input  c_in,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sat
  );

  modport master (
    output in_valid,
    output s_in,
    output c_in,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sat
  );
endinterface

// File: rtl/csa_resolve_accum.sv
// Resolves carry-save sum/carry pairs in a split pipelined adder and
// accumulates them per frame into one saturated filter output.
module csa_resolve_accum #(
  parameter int W     = 12,
  parameter int ACC_W = 20
) (
  input logic                clk,
  input logic                rst_n,
  input logic                clr,
  csa_resolve_accum_if.slave bus
);
  localparam int OW = W + 2;
  localparam int LO = OW / 2;
  localparam int HI = OW - LO;

  localparam logic [1:0] ACC   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  typedef struct packed {
    logic         v;
    logic         last;
    logic [W-1:0] s;
    logic [W-1:0] c;
  } in_t;

  typedef struct packed {
    logic          v;
    logic          last;
    logic          cy;
    logic [LO-1:0] lo;
    logic [HI-1:0] a_hi;
    logic [HI-1:0] b_hi;
  } p1_t;

  typedef struct packed {
    logic          v;
    logic          last;
    logic [OW-1:0] op;
  } p2_t;

  logic [1:0]       state;
  in_t              in_q;
  p1_t              p1_q;
  p2_t              p2_q;
  logic [ACC_W-1:0] acc;
  logic             sat;

  logic             out_valid_q;
  logic [ACC_W-1:0] out_data_q;
  logic             out_sat_q;

  logic             in_ready;
  logic             accept;
  logic [OW-1:0]    op_a;
  logic [OW-1:0]    op_b;
  logic [LO:0]      lo_sum;
  logic [HI-1:0]    hi_sum;
  logic [ACC_W:0]   acc_sum;
  logic             ovf_pos;
  logic             ovf_neg;
  logic [ACC_W-1:0] acc_nxt;
  logic             sat_nxt;

  assign in_ready = (state == ACC);
  assign accept   = bus.in_valid & in_ready;

  // carry vector bits weigh one position higher than sum bits
  assign op_a = {{2{in_q.s[W-1]}}, in_q.s};
  assign op_b = {in_q.c[W-1], in_q.c, 1'b0};

  assign lo_sum = {1'b0, op_a[LO-1:0]}
                + {1'b0, op_b[LO-1:0]};

  assign hi_sum = p1_q.a_hi + p1_q.b_hi
                + {{(HI-1){1'b0}}, p1_q.cy};

  assign acc_sum =
    {acc[ACC_W-1], acc}
    + {{(ACC_W+1-OW){p2_q.op[OW-1]}}, p2_q.op};

  assign ovf_pos = ~acc_sum[ACC_W] & acc_sum[ACC_W-1];
  assign ovf_neg = acc_sum[ACC_W] & ~acc_sum[ACC_W-1];

  always_comb begin
    acc_nxt = acc_sum[ACC_W-1:0];
    unique case (1'b1)
      ovf_pos: acc_nxt = ACC_MAX;
      ovf_neg: acc_nxt = ACC_MIN;
      default: ;
    endcase
  end

  assign sat_nxt = sat | ovf_pos | ovf_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
    end else if (clr) begin
      in_q.v <= 1'b0;
      p1_q.v <= 1'b0;
      p2_q.v <= 1'b0;
    end else begin
      in_q.v <= accept;
      if (accept) begin
        in_q.last <= bus.in_last;
        in_q.s    <= bus.s_in;
        in_q.c    <= bus.c_in;
      end
      p1_q.v    <= in_q.v;
      p1_q.last <= in_q.last;
      p1_q.cy   <= lo_sum[LO];
      p1_q.lo   <= lo_sum[LO-1:0];
      p1_q.a_hi <= op_a[OW-1:LO];
      p1_q.b_hi <= op_b[OW-1:LO];
      p2_q.v    <= p1_q.v;
      p2_q.last <= p1_q.last;
      p2_q.op   <= {hi_sum, p1_q.lo};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACC;
      acc         <= '0;
      sat         <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (clr) begin
      state       <= ACC;
      acc         <= '0;
      sat         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (p2_q.v) begin
        acc <= acc_nxt;
        sat <= sat_nxt;
      end
      case (state)
        ACC: begin
          if (accept && bus.in_last) state <= DRAIN;
        end
        DRAIN: begin
          if (p2_q.v && p2_q.last) begin
            state       <= HOLD;
            out_valid_q <= 1'b1;
            out_data_q  <= acc_nxt;
            out_sat_q   <= sat_nxt;
          end
        end
        HOLD: begin
          // pipeline is empty here, so the clear cannot race an update
          if (bus.out_ready) begin
            state       <= ACC;
            out_valid_q <= 1'b0;
            acc         <= '0;
            sat         <= 1'b0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
endmodule
